decoder_nbit_pulse: RTL and testbench
=====================================

// Module: decoder_nbit_pulse
// PURPOSE
// - Parametrised successor to the 1-bit two-output decoder: SEL_W-bit select drives 2**SEL_W one-hot outputs.
// - Each accepted select becomes a registered one-hot pulse of PULSE_LEN cycles, followed by GAP_LEN idle cycles.
// - A valid/ready handshake makes it a command-driven strobe generator, e.g. for bank/row enables in TC-Bench datapaths.
// PARAMETERS
// - SEL_W      2   select width; output width OUT_W = 2**SEL_W (SEL_W >= 1)
// - PULSE_LEN  3   cycles the decoded output stays high (>= 1)
// - GAP_LEN    1   mandatory all-zero cycles after each pulse (>= 0)
// PORTS
// - clk        in   1       single clock; all state updates on posedge
// - rst        in   1       synchronous, active-high reset
// - in_valid   in   1       command present
// - in_sel     in   SEL_W   select to decode; sampled only on accept
// - in_ready   out  1       block can accept; high only in IDLE
// - out        out  OUT_W   registered one-hot pulse; all-zero otherwise
// - busy       out  1       high in PULSE or GAP (= ~in_ready)
// - cmd_count  out  16      accepted-command counter (only with DECODER_CNT_EN)
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, out=0, counter=0, cmd_count=0; in_ready=1 and busy=0 from the next cycle.
// - Reset wins over everything; rst asserted mid-PULSE/GAP aborts: out=0 the next cycle, pending command lost.
// - Accept = in_valid & in_ready at posedge. in_ready is combinational from state only, never from in_valid.
// - FSM states IDLE, PULSE, GAP:
// -   IDLE: on accept -> PULSE; out <= 1<<in_sel; counter <= PULSE_LEN-1. Otherwise stay, out=0.
// -   PULSE: out held. If counter==0 -> GAP with counter<=GAP_LEN-1, or -> IDLE if GAP_LEN==0; out<=0. Else counter--.
// -   GAP: out=0. If counter==0 -> IDLE, else counter--.
// - Latency: accept at edge k -> out one-hot during cycles k+1 .. k+PULSE_LEN; in_ready high again at cycle k+PULSE_LEN+GAP_LEN+1.
// - Minimum accept-to-accept spacing is PULSE_LEN+GAP_LEN+1 cycles; no back-to-back acceptance, no queuing.
// - in_valid/in_sel while busy are ignored; the producer must hold in_valid until accepted.
// - out is exactly one-hot or zero at every cycle; never two bits; glitch-free (flop outputs).
// - in_sel is fully decoded: every value 0..OUT_W-1 is legal; X on in_sel at accept is a bench error.
// - Counter width = $clog2(max(PULSE_LEN,GAP_LEN)+1), minimum 1 bit; no wrap within a phase.
// CONFIGURATION
// - DECODER_CNT_EN defined: cmd_count port present; increments by 1 on every accept, wraps 16'hFFFF -> 0; cleared by rst.
// - DECODER_CNT_EN undefined: cmd_count port and counter logic absent; all other behaviour identical.
// TESTING
// - Reset: rst=1 for 2 cycles with in_valid=1 -> out=0, busy=0, in_ready=1 after release; no pulse emitted.
// - Defaults, in_sel=2'd2 accepted at edge k -> out=4'b0100 for cycles k+1..k+3, 0 at k+4, in_ready=1 at k+5.
// - Sweep in_sel 0..3 with in_valid held high -> out 0001,0010,0100,1000, one command per 5 cycles, never overlapping.
// - in_sel changed 2->1 mid-PULSE -> out stays 4'b0100; the new value is ignored until IDLE.
// - rst pulsed at 2nd PULSE cycle -> out=0 next cycle, in_ready=1 after release, cmd_count=0 (CNT_EN).
// - SEL_W=3, PULSE_LEN=1, GAP_LEN=0, DECODER_CNT_EN: 10 accepts of sel=7 -> out=8'h80 one cycle each, gap 1 cycle, cmd_count=10.

Source files
------------

// File: rtl/decoder_nbit_pulse.sv
// Command-driven one-hot strobe generator: each accepted select becomes a PULSE_LEN-cycle
// registered one-hot pulse followed by GAP_LEN idle cycles. Define DECODER_CNT_EN for cmd_count.
module decoder_nbit_pulse #(
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic                    busy
`ifdef DECODER_CNT_EN
    ,
    output logic [15:0]             cmd_count
`endif
);

    localparam int OUT_W   = 1 << SEL_W;
    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN + 1);
    localparam bit HAS_GAP = (GAP_LEN > 0);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(HAS_GAP ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [OUT_W-1:0]   out_reg, out_next;
    logic [OUT_W-1:0]   sel_onehot;
    logic               accept;

    // Full decode of the select; exactly one bit set for any legal in_sel.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign sel_onehot[gi] = (in_sel == SEL_W'(gi));
        end
    endgenerate

    assign in_ready = (state_reg == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready;
    assign out      = out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE: begin
                out_next = '0;
                if (accept) begin
                    state_next = PULSE;
                    out_next   = sel_onehot;
                    cnt_next   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_reg == '0) begin
                    out_next = '0;
                    if (HAS_GAP) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            GAP: begin
                out_next = '0;
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                out_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef DECODER_CNT_EN
    logic [15:0] cmd_count_reg;

    // Free-running accept counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count_reg <= '0;
        end else if (accept) begin
            cmd_count_reg <= cmd_count_reg + 16'd1;
        end
    end

    assign cmd_count = cmd_count_reg;
`endif

endmodule

// File: tb/tb_decoder_nbit_pulse.sv
// Scoreboard bench for decoder_nbit_pulse: default instance (4 outputs) and a
// SEL_W=3 / PULSE_LEN=1 / GAP_LEN=0 instance, with per-cycle expected-output queues.
module tb_decoder_nbit_pulse;

    localparam int A_PULSE = 3;
    localparam int A_GAP   = 1;
    localparam int B_PULSE = 1;
    localparam int B_GAP   = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       va  = 1'b0;
    logic       vb  = 1'b0;
    logic [1:0] sa  = '0;
    logic [2:0] sb  = '0;
    logic [3:0] out_a;
    logic [7:0] out_b;
    logic       rdy_a, rdy_b, busy_a, busy_b;
`ifdef DECODER_CNT_EN
    logic [15:0] cnt_a, cnt_b;
    logic [15:0] exp_cnt_a = '0;
    logic [15:0] exp_cnt_b = '0;
`endif

    always #5 clk = ~clk;

    decoder_nbit_pulse #(.SEL_W(2), .PULSE_LEN(A_PULSE), .GAP_LEN(A_GAP)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (va),
        .in_sel   (sa),
        .in_ready (rdy_a),
        .out      (out_a),
        .busy     (busy_a)
`ifdef DECODER_CNT_EN
        ,
        .cmd_count(cnt_a)
`endif
    );

    decoder_nbit_pulse #(.SEL_W(3), .PULSE_LEN(B_PULSE), .GAP_LEN(B_GAP)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vb),
        .in_sel   (sb),
        .in_ready (rdy_b),
        .out      (out_b),
        .busy     (busy_b)
`ifdef DECODER_CNT_EN
        ,
        .cmd_count(cnt_b)
`endif
    );

    typedef struct packed {
        logic [7:0] o;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cycle_no     = 0;
    int   seen_b80     = 0;
    bit   armed        = 1'b0;
    bit   acc_a        = 1'b0;
    bit   acc_b        = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle_no, got, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, then drive inputs for the next edge
    // and push the expected cycles of any command that will be accepted.
    task automatic cyc(input logic r, input logic v1, input logic [1:0] s1,
                       input logic v2, input logic [2:0] s2);
        exp_t ea, eb, e;
        @(negedge clk);
        cycle_no++;
        if (qa.size() > 0) ea = qa.pop_front();
        else begin ea.o = 8'h00; ea.rdy = 1'b1; ea.bsy = 1'b0; end
        if (qb.size() > 0) eb = qb.pop_front();
        else begin eb.o = 8'h00; eb.rdy = 1'b1; eb.bsy = 1'b0; end
        if (armed) begin
            chk("a_out",   32'(out_a),  32'(ea.o));
            chk("a_ready", 32'(rdy_a),  32'(ea.rdy));
            chk("a_busy",  32'(busy_a), 32'(ea.bsy));
            chk("b_out",   32'(out_b),  32'(eb.o));
            chk("b_ready", 32'(rdy_b),  32'(eb.rdy));
            chk("b_busy",  32'(busy_b), 32'(eb.bsy));
`ifdef DECODER_CNT_EN
            chk("a_cmd_count", 32'(cnt_a), 32'(exp_cnt_a));
            chk("b_cmd_count", 32'(cnt_b), 32'(exp_cnt_b));
`endif
            if (out_b === 8'h80) seen_b80++;
        end
        rst = r; va = v1; sa = s1; vb = v2; sb = s2;
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (r) begin
            qa.delete();
            qb.delete();
            armed = 1'b1;
`ifdef DECODER_CNT_EN
            exp_cnt_a = '0;
            exp_cnt_b = '0;
`endif
        end else if (armed) begin
            if (v1 && ea.rdy) begin
                acc_a = 1'b1;
                e.rdy = 1'b0; e.bsy = 1'b1;
                e.o = 8'd1 << s1;
                for (int i = 0; i < A_PULSE; i++) qa.push_back(e);
                e.o = 8'h00;
                for (int i = 0; i < A_GAP; i++) qa.push_back(e);
`ifdef DECODER_CNT_EN
                exp_cnt_a = exp_cnt_a + 16'd1;
`endif
                $display("[TB] cycle %0d: A accept sel=%0d", cycle_no, s1);
            end
            if (v2 && eb.rdy) begin
                acc_b = 1'b1;
                e.rdy = 1'b0; e.bsy = 1'b1;
                e.o = 8'd1 << s2;
                for (int i = 0; i < B_PULSE; i++) qb.push_back(e);
                e.o = 8'h00;
                for (int i = 0; i < B_GAP; i++) qb.push_back(e);
`ifdef DECODER_CNT_EN
                exp_cnt_b = exp_cnt_b + 16'd1;
`endif
                $display("[TB] cycle %0d: B accept sel=%0d", cycle_no, s2);
            end
        end
    endtask

    // Hold a command on A until the scoreboard predicts it is taken.
    task automatic send_a(input logic [1:0] s);
        int n;
        for (n = 0; n < 20; n++) begin
            cyc(1'b0, 1'b1, s, 1'b0, 3'd0);
            if (acc_a) break;
        end
        if (!acc_a) chk("a_accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset held two cycles with valid asserted: nothing may be emitted.
        cyc(1'b1, 1'b1, 2'd1, 1'b1, 3'd5);
        cyc(1'b1, 1'b1, 2'd3, 1'b1, 3'd7);
        repeat (3) cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

        // Single command, sel=2.
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
        repeat (6) cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

        // Sweep with valid held high.
        for (int i = 0; i < 4; i++) send_a(2'(i));
        repeat (6) cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

        // Select changes while pulsing: pulse stays on the original bit.
        send_a(2'd2);
        send_a(2'd1);
        repeat (6) cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

        // Reset during the second pulse cycle aborts the pulse.
        send_a(2'd3);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 2'd0, 1'b0, 3'd0);
        repeat (4) cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

        // Narrow instance: ten back-to-back sel=7 commands, one-cycle pulses.
        seen_b80 = 0;
        begin
            int n_acc;
            n_acc = 0;
            for (int n = 0; n < 40 && n_acc < 10; n++) begin
                cyc(1'b0, 1'b0, 2'd0, 1'b1, 3'd7);
                if (acc_b) n_acc++;
            end
            if (n_acc < 10) chk("b_accept_timeout", 32'(n_acc), 32'd10);
        end
        repeat (3) cyc(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
        chk("b_pulse_count", 32'(seen_b80), 32'd10);
`ifdef DECODER_CNT_EN
        chk("b_cmd_count_total", 32'(cnt_b), 32'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
